// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: fetch PC, one-cycle-latency memory reads, 2-entry skid FIFO, valid/ready output.
// Optional IFETCH_STATS_EN adds fetch_cnt / stall_cnt performance counters.
//
// Handshake: an instruction transfers on a cycle where inst_valid && inst_ready at the rising clk edge;
// inst/inst_pc stay stable while inst_valid is high and inst_ready is low; inst_valid never depends on inst_ready.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        state_dbg
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;

  assign iaddr      = fetch_pc;
  assign inst_valid = (count != 2'd0);
  assign inst       = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign state_dbg  = (state == RUN);

  assign pop  = inst_valid & inst_ready;
  assign push = inflight;
  // Occupancy after this cycle's pop; pop implies count >= 1, so no underflow.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == RUN) & ~redirect_valid & (occ < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= 32'd0;
      fifo_data[0] <= 32'd0;
      fifo_data[1] <= 32'd0;
      fifo_pc[0]   <= 32'd0;
      fifo_pc[1]   <= 32'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      state <= RUN;
      if (redirect_valid) begin
        // Flush: buffered words and the in-flight read are both dropped.
        fetch_pc <= redirect_pc;
        inflight <= 1'b0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        count    <= 2'd0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + PC_STEP;
        end
        if (push) begin
          fifo_data[wr_ptr] <= idata;
          fifo_pc[wr_ptr]   <= inflight_pc;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (issue) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if ((state == RUN) && !issue && !redirect_valid) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit with a behavioural 1-cycle-latency memory mem[k] = A000_0000 + k.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        state_dbg;
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .iaddr          (iaddr),
    .idata          (idata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .state_dbg      (state_dbg)
`ifdef IFETCH_STATS_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) idata <= 32'hA000_0000 + iaddr;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare outputs of the current cycle, then drive this cycle's inputs and advance.
  task automatic apply(input int i);
    vec_t v;
    v = vq[i];
    chk($sformatf("v%0d.valid", i), {31'd0, inst_valid}, {31'd0, v.ev});
    chk($sformatf("v%0d.iaddr", i), iaddr, v.eaddr);
    if (v.ev) begin
      chk($sformatf("v%0d.inst_pc", i), inst_pc, v.epc);
      chk($sformatf("v%0d.inst", i), inst, 32'hA000_0000 + v.epc);
    end
    drive(v.rdy, v.redir, v.rpc);
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, ".iaddr"}, iaddr, 32'd0);
    chk({tag, ".inst"}, inst, 32'd0);
    chk({tag, ".inst_pc"}, inst_pc, 32'd0);
    chk({tag, ".state"}, {31'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    // rdy, redir, rpc, exp_valid, exp_pc, exp_iaddr
    add(1, 0, 0, 0, 0, 0);            // 0 BOOT
    add(1, 0, 0, 0, 0, 0);            // 1 first issue
    add(1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 2);            // 3 first instruction
    add(1, 0, 0, 1, 1, 3);
    add(0, 0, 0, 1, 2, 4);            // 5..9 backpressure
    add(0, 0, 0, 1, 2, 4);
    add(0, 0, 0, 1, 2, 4);
    add(0, 0, 0, 1, 2, 4);
    add(0, 0, 0, 1, 2, 4);
    add(1, 0, 0, 1, 2, 4);            // 10 resume
    add(1, 0, 0, 1, 3, 5);
    add(1, 0, 0, 1, 4, 6);
    add(0, 1, 32'h40, 1, 5, 7);       // 13 redirect with word buffered and in flight
    add(1, 0, 0, 0, 0, 32'h40);
    add(1, 0, 0, 0, 0, 32'h41);
    add(1, 0, 0, 1, 32'h40, 32'h42);  // 16 target
    add(1, 1, 32'h10, 1, 32'h41, 32'h43);
    add(1, 1, 32'h20, 0, 0, 32'h10);  // 18 second redirect wins
    add(1, 0, 0, 0, 0, 32'h20);
    add(1, 0, 0, 0, 0, 32'h21);
    add(1, 0, 0, 1, 32'h20, 32'h22);
    add(1, 1, 32'hFFFF_FFFF, 1, 32'h21, 32'h23);
    add(1, 0, 0, 0, 0, 32'hFFFF_FFFF);
    add(1, 0, 0, 0, 0, 32'h0);        // 24 PC wrapped
    add(1, 0, 0, 1, 32'hFFFF_FFFF, 32'h1);
    add(1, 0, 0, 1, 32'h0, 32'h2);

    rst = 1'b1;
    drive(1'b1, 1'b0, 32'd0);
    #1;
    chk_reset("rst0");
    step();
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) apply(i);

    // Async reset pulse between clock edges
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) apply(i);

    // Redirect during BOOT still enters RUN next cycle
    #2 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    drive(1'b1, 1'b1, 32'h80);
    step();
    chk("boot_redir.state", {31'd0, state_dbg}, 32'd1);
    chk("boot_redir.iaddr0", iaddr, 32'h80);
    drive(1'b1, 1'b0, 32'd0);
    step();
    chk("boot_redir.iaddr1", iaddr, 32'h81);
    chk("boot_redir.valid1", {31'd0, inst_valid}, 32'd0);
    step();
    chk("boot_redir.valid2", {31'd0, inst_valid}, 32'd1);
    chk("boot_redir.pc", inst_pc, 32'h80);
    chk("boot_redir.inst", inst, 32'hA000_0080);

`ifdef IFETCH_STATS_EN
    // 10 fetches (cycles 1..10), then 4 backpressure stalls
    #2 rst = 1'b1;
    #1;
    chk("stats.rst_fetch", fetch_cnt, 32'd0);
    chk("stats.rst_stall", stall_cnt, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 11; i++) step();
    drive(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("stats.fetch_cnt", fetch_cnt, 32'd10);
    chk("stats.stall_cnt", stall_cnt, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
